// File: rtl/range_dispatcher_if.sv
// range_dispatcher_if
// Bundles the range input stream, the calculator request/result handshake
// and the job result outputs of range_dispatcher.
//   master : dispatcher side (takes ranges, drives calculator requests,
//            publishes the job total)
//   slave  : environment side (range source, calculator, result consumer)
// Range stream: a range moves on the rising clk edge where rng_valid and
// rng_ready are both high; the source holds rng_start/rng_end/rng_last
// stable until that edge. Calculator: calc_start is a level request held
// until calc_done is seen, and calc_done stays high until calc_start drops.
interface range_dispatcher_if;
   logic        rng_valid;
   logic        rng_ready;
   logic [39:0] rng_start;
   logic [39:0] rng_end;
   logic        rng_last;
   logic        calc_start;
   logic [39:0] calc_range_start;
   logic [39:0] calc_range_end;
   logic [3:0]  calc_k;
   logic [63:0] calc_sum;
   logic        calc_done;
   logic [63:0] total;
   logic        total_valid;
   logic        overflow;
   logic        busy;
   logic [2:0]  dbg_state;

   modport master (
      input  rng_valid, rng_start, rng_end, rng_last, calc_sum, calc_done,
      output rng_ready, calc_start, calc_range_start, calc_range_end, calc_k,
             total, total_valid, overflow, busy, dbg_state
   );

   modport slave (
      output rng_valid, rng_start, rng_end, rng_last, calc_sum, calc_done,
      input  rng_ready, calc_start, calc_range_start, calc_range_end, calc_k,
             total, total_valid, overflow, busy, dbg_state
   );
endinterface

// File: rtl/range_dispatcher.sv
// range_dispatcher
// Accepts ID ranges, issues one calculator request per half-length k
// (1..K_MAX) whose repeated-half numbers can overlap the range, sums the
// returned partial sums into a 64-bit accumulator and publishes the total
// when the range flagged last has been processed.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : range_dispatcher_if.master (range stream, calculator handshake,
//          total/total_valid/overflow/busy, dbg_state = FSM state encoding)
module range_dispatcher #(
   parameter int unsigned K_MAX = 6
) (
   input logic             clk,
   input logic             rst,
   range_dispatcher_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_CHECK     = 3'd1,
      S_ISSUE     = 3'd2,
      S_WAIT      = 3'd3,
      S_RELEASE   = 3'd4,
      S_RANGE_END = 3'd5
   } state_t;

   // Smallest repeated-half number with half-length k: 10^(k-1)*(10^k+1).
   // Bit 40 marks k values whose numbers cannot fit a 40-bit ID, so every
   // range end compares below them and the scan stops.
   function automatic logic [40:0] lo_of(input logic [3:0] k);
      case (k)
         4'd1:    lo_of = 41'd11;
         4'd2:    lo_of = 41'd1010;
         4'd3:    lo_of = 41'd100100;
         4'd4:    lo_of = 41'd10001000;
         4'd5:    lo_of = 41'd1000010000;
         4'd6:    lo_of = 41'd100000100000;
         default: lo_of = {1'b1, 40'd0};
      endcase
   endfunction

   // Largest ID with 2k digits: 10^(2k)-1.
   function automatic logic [40:0] hi_of(input logic [3:0] k);
      case (k)
         4'd1:    hi_of = 41'd99;
         4'd2:    hi_of = 41'd9999;
         4'd3:    hi_of = 41'd999999;
         4'd4:    hi_of = 41'd99999999;
         4'd5:    hi_of = 41'd9999999999;
         4'd6:    hi_of = 41'd999999999999;
         default: hi_of = {1'b1, 40'd0};
      endcase
   endfunction

   state_t      state_q, state_d;
   logic [39:0] start_q, start_d;
   logic [39:0] end_q, end_d;
   logic        last_q, last_d;
   logic [3:0]  k_q, k_d;
   logic        calc_start_q, calc_start_d;
   logic [63:0] acc_q, acc_d;
   logic [63:0] total_q, total_d;
   logic        total_valid_q, total_valid_d;
   logic        overflow_q, overflow_d;
   logic        below_lo_q, below_lo_d;
   logic        above_hi_q, above_hi_d;
   logic [64:0] sum_ext;

   always_comb begin
      state_d       = state_q;
      start_d       = start_q;
      end_d         = end_q;
      last_d        = last_q;
      k_d           = k_q;
      calc_start_d  = calc_start_q;
      acc_d         = acc_q;
      total_d       = total_q;
      total_valid_d = 1'b0;
      overflow_d    = overflow_q;
      sum_ext       = {1'b0, acc_q} + {1'b0, bus.calc_sum};

      case (state_q)
         S_IDLE: begin
            if (bus.rng_valid) begin
               start_d    = bus.rng_start;
               end_d      = bus.rng_end;
               last_d     = bus.rng_last;
               k_d        = 4'd1;
               overflow_d = 1'b0;
               state_d    = (bus.rng_start > bus.rng_end) ? S_RANGE_END : S_CHECK;
            end
         end
         S_CHECK: begin
            if (below_lo_q) begin
               state_d = S_RANGE_END;
            end else if (above_hi_q) begin
               if (k_q == 4'(K_MAX)) state_d = S_RANGE_END;
               else                  k_d     = k_q + 4'd1;
            end else begin
               calc_start_d = 1'b1;
               state_d      = S_ISSUE;
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (bus.calc_done) begin
               acc_d        = sum_ext[63:0];
               if (sum_ext[64]) overflow_d = 1'b1;
               calc_start_d = 1'b0;
               state_d      = S_RELEASE;
            end
         end
         S_RELEASE: begin
            // A done left over from the previous request must be seen low
            // before the next request, or it would be taken as its result.
            if (!bus.calc_done) begin
               if (k_q == 4'(K_MAX)) begin
                  state_d = S_RANGE_END;
               end else begin
                  k_d     = k_q + 4'd1;
                  state_d = S_CHECK;
               end
            end
         end
         S_RANGE_END: begin
            if (last_q) begin
               total_d       = acc_q;
               total_valid_d = 1'b1;
               acc_d         = '0;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Compares are evaluated against the k and bounds S_CHECK will see
      // next cycle, so each S_CHECK cycle decides from registered results.
      below_lo_d = ({1'b0, end_d} < lo_of(k_d));
      above_hi_d = ({1'b0, start_d} > hi_of(k_d));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         start_q       <= '0;
         end_q         <= '0;
         last_q        <= 1'b0;
         k_q           <= '0;
         calc_start_q  <= 1'b0;
         acc_q         <= '0;
         total_q       <= '0;
         total_valid_q <= 1'b0;
         overflow_q    <= 1'b0;
         below_lo_q    <= 1'b0;
         above_hi_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         start_q       <= start_d;
         end_q         <= end_d;
         last_q        <= last_d;
         k_q           <= k_d;
         calc_start_q  <= calc_start_d;
         acc_q         <= acc_d;
         total_q       <= total_d;
         total_valid_q <= total_valid_d;
         overflow_q    <= overflow_d;
         below_lo_q    <= below_lo_d;
         above_hi_q    <= above_hi_d;
      end
   end

   assign bus.rng_ready        = (state_q == S_IDLE) && !rst;
   assign bus.calc_start       = calc_start_q;
   assign bus.calc_range_start = start_q;
   assign bus.calc_range_end   = end_q;
   assign bus.calc_k           = k_q;
   assign bus.total            = total_q;
   assign bus.total_valid      = total_valid_q;
   assign bus.overflow         = overflow_q;
   assign bus.busy             = (state_q != S_IDLE);
   assign bus.dbg_state        = state_q;

endmodule

// File: tb/tb_range_dispatcher.sv
// tb_range_dispatcher
// Directed bench for range_dispatcher with a stub calculator that returns
// the true repeated-half sum (or a forced value) and flags protocol abuse.
module tb_range_dispatcher;

   logic clk;
   logic rst;
   range_dispatcher_if bus();

   range_dispatcher #(.K_MAX(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- stub calculator ----------------
   int          stub_lat   = 1;
   int          stub_extra = 0;
   logic        force_en   = 1'b0;
   logic [63:0] force_val  = '0;
   int          n_req      = 0;
   int          proto_err  = 0;
   logic [3:0]  iss_q[$];
   logic [3:0]  exp_q[$];

   function automatic longint unsigned rep_sum(input logic [39:0] s, input logic [39:0] e,
                                               input logic [3:0] k);
      longint unsigned p, m, a, b, s64, e64;
      if (k == 4'd0) return 0;
      p = 1;
      for (int i = 0; i < int'(k); i++) p = p * 10;
      m   = p + 1;
      s64 = 64'(s);
      e64 = 64'(e);
      a = (s64 + m - 1) / m;
      if (a < p / 10) a = p / 10;
      b = e64 / m;
      if (b > p - 1) b = p - 1;
      if (a > b) return 0;
      return m * (((a + b) * (b - a + 1)) / 2);
   endfunction

   initial begin
      int st;
      int cnt;
      logic prev_start;
      st = 0; cnt = 0; prev_start = 1'b0;
      bus.calc_done = 1'b0;
      bus.calc_sum  = '0;
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            st = 0;
            bus.calc_done = 1'b0;
            prev_start = 1'b0;
         end else begin
            if (bus.calc_start && !prev_start && st != 0) proto_err++;
            case (st)
               0: if (bus.calc_start) begin
                     iss_q.push_back(bus.calc_k);
                     n_req++;
                     cnt = stub_lat;
                     st  = 1;
                  end
               1: if (cnt == 0) begin
                     bus.calc_sum  = force_en ? force_val
                                              : rep_sum(bus.calc_range_start, bus.calc_range_end, bus.calc_k);
                     bus.calc_done = 1'b1;
                     st = 2;
                  end else cnt--;
               2: if (!bus.calc_start) begin
                     cnt = 1 + stub_extra;
                     st  = 3;
                  end
               default: if (cnt == 0) begin
                     bus.calc_done = 1'b0;
                     st = 0;
                  end else cnt--;
            endcase
            prev_start = bus.calc_start;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_range(input logic [39:0] s, input logic [39:0] e, input logic l);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      bus.rng_valid = 1'b1;
      bus.rng_start = s;
      bus.rng_end   = e;
      bus.rng_last  = l;
      for (int i = 0; i < 400; i++) begin
         if (bus.rng_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (ok) @(posedge clk);
      #1 bus.rng_valid = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL range_accept: accepted=%0d required=1 (start %0d)", ok, s);
      end
   endtask

   task automatic wait_total(output bit got, output logic [63:0] tot, output logic ovf,
                             output logic rdy, output logic bsy, output logic tv_next);
      got = 1'b0; tot = '0; ovf = 1'b0; rdy = 1'b0; bsy = 1'b1; tv_next = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (bus.total_valid) begin
            got = 1'b1;
            tot = bus.total;
            ovf = bus.overflow;
            rdy = bus.rng_ready;
            bsy = bus.busy;
            break;
         end
      end
      if (got) begin
         @(negedge clk);
         tv_next = bus.total_valid;
      end
   endtask

   task automatic clear_log();
      n_req = 0;
      proto_err = 0;
      iss_q.delete();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (bus.rng_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0d required 0", bus.rng_ready); end
      checks++; if (bus.calc_start !== 1'b0) begin errors++; $display("FAIL reset_calc_start: got %0d required 0", bus.calc_start); end
      checks++; if (bus.calc_k !== 4'd0) begin errors++; $display("FAIL reset_calc_k: got %0d required 0", bus.calc_k); end
      checks++; if (bus.calc_range_start !== 40'd0 || bus.calc_range_end !== 40'd0) begin errors++; $display("FAIL reset_calc_range: got %0d/%0d required 0/0", bus.calc_range_start, bus.calc_range_end); end
      checks++; if (bus.total !== 64'd0 || bus.total_valid !== 1'b0) begin errors++; $display("FAIL reset_total: got %0d/%0d required 0/0", bus.total, bus.total_valid); end
      checks++; if (bus.overflow !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf %0d busy %0d required 0 0", bus.overflow, bus.busy); end
      checks++; if (bus.dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", bus.dbg_state); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (bus.rng_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %0d required 1", bus.rng_ready); end
   endtask

   task automatic test_single();
      bit got; logic [63:0] tot; logic ovf, rdy, bsy, tvn;
      clear_log();
      send_range(40'd11, 40'd22, 1'b1);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %0d required 1", bus.busy); end
      wait_total(got, tot, ovf, rdy, bsy, tvn);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL single_timeout: got %0d required 1", got); end
      checks++; if (tot !== 64'd33) begin errors++; $display("FAIL single_total: got %0d required 33", tot); end
      checks++; if (n_req !== 1 || iss_q.size() != 1) begin errors++; $display("FAIL single_nreq: got %0d required 1", n_req); end
      else begin
         checks++; if (iss_q[0] !== 4'd1) begin errors++; $display("FAIL single_k: got %0d required 1", iss_q[0]); end
      end
      checks++; if (rdy !== 1'b1 || bsy !== 1'b0) begin errors++; $display("FAIL single_ready_at_valid: got rdy %0d busy %0d required 1 0", rdy, bsy); end
      checks++; if (tvn !== 1'b0) begin errors++; $display("FAIL single_pulse_width: got %0d required 0", tvn); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL single_overflow: got %0d required 0", ovf); end
   endtask

   task automatic test_back_to_back();
      bit got; logic [63:0] tot; logic ovf, rdy, bsy, tvn;
      clear_log();
      exp_q = '{4'd1, 4'd1, 4'd2, 4'd5};
      send_range(40'd11, 40'd22, 1'b0);
      send_range(40'd95, 40'd115, 1'b0);
      send_range(40'd998, 40'd1012, 1'b0);
      send_range(40'd1188511880, 40'd1188511890, 1'b1);
      wait_total(got, tot, ovf, rdy, bsy, tvn);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL multi_timeout: got %0d required 1", got); end
      checks++; if (tot !== 64'd1188513027) begin errors++; $display("FAIL multi_total: got %0d required 1188513027", tot); end
      checks++; if (n_req !== 4) begin errors++; $display("FAIL multi_nreq: got %0d required 4", n_req); end
      while (exp_q.size() > 0) begin
         logic [3:0] e, a;
         e = exp_q.pop_front();
         a = (iss_q.size() > 0) ? iss_q.pop_front() : 4'd0;
         checks++; if (a !== e) begin errors++; $display("FAIL multi_k: got %0d required %0d", a, e); end
      end
   endtask

   task automatic test_no_match();
      bit got; logic [63:0] tot; logic ovf, rdy, bsy, tvn;
      clear_log();
      send_range(40'd1, 40'd10, 1'b1);
      wait_total(got, tot, ovf, rdy, bsy, tvn);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL nomatch_timeout: got %0d required 1", got); end
      checks++; if (tot !== 64'd0) begin errors++; $display("FAIL nomatch_total: got %0d required 0", tot); end
      checks++; if (n_req !== 0) begin errors++; $display("FAIL nomatch_nreq: got %0d required 0", n_req); end
   endtask

   task automatic test_empty();
      bit got; logic [63:0] tot; logic ovf, rdy, bsy, tvn;
      clear_log();
      send_range(40'd500, 40'd400, 1'b1);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL empty_busy: got %0d required 1", bus.busy); end
      wait_total(got, tot, ovf, rdy, bsy, tvn);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL empty_timeout: got %0d required 1", got); end
      checks++; if (tot !== 64'd0) begin errors++; $display("FAIL empty_total: got %0d required 0", tot); end
      checks++; if (n_req !== 0) begin errors++; $display("FAIL empty_nreq: got %0d required 0", n_req); end
   endtask

   task automatic test_stale_done();
      bit got; logic [63:0] tot; logic ovf, rdy, bsy, tvn;
      clear_log();
      stub_extra = 5;
      // k=1 covers 11..99 (495), k=2 covers 1010 only
      send_range(40'd11, 40'd1010, 1'b1);
      wait_total(got, tot, ovf, rdy, bsy, tvn);
      stub_extra = 0;
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL stale_timeout: got %0d required 1", got); end
      checks++; if (tot !== 64'd1505) begin errors++; $display("FAIL stale_total: got %0d required 1505", tot); end
      checks++; if (n_req !== 2) begin errors++; $display("FAIL stale_nreq: got %0d required 2", n_req); end
      checks++; if (proto_err !== 0) begin errors++; $display("FAIL stale_start_early: got %0d required 0", proto_err); end
   endtask

   task automatic test_overflow();
      bit got; logic [63:0] tot; logic ovf, rdy, bsy, tvn;
      clear_log();
      force_en  = 1'b1;
      force_val = 64'h8000_0000_0000_0000;
      send_range(40'd11, 40'd1010, 1'b1);
      wait_total(got, tot, ovf, rdy, bsy, tvn);
      force_en = 1'b0;
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL ovf_timeout: got %0d required 1", got); end
      checks++; if (tot !== 64'd0) begin errors++; $display("FAIL ovf_total: got %0d required 0", tot); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0d required 1", ovf); end
      checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky_idle: got %0d required 1", bus.overflow); end
      // next accepted range clears the flag
      clear_log();
      send_range(40'd11, 40'd22, 1'b1);
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0d required 0", bus.overflow); end
      wait_total(got, tot, ovf, rdy, bsy, tvn);
      checks++; if (tot !== 64'd33 || ovf !== 1'b0) begin errors++; $display("FAIL ovf_next_job: got %0d ovf %0d required 33 ovf 0", tot, ovf); end
   endtask

   task automatic test_reset_mid();
      bit got, seen; logic [63:0] tot; logic ovf, rdy, bsy, tvn;
      clear_log();
      stub_lat = 20;
      send_range(40'd11, 40'd22, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.calc_start) begin seen = 1'b1; break; end
      end
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rstmid_start: got %0d required 1", seen); end
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checks++; if (bus.calc_start !== 1'b0) begin errors++; $display("FAIL rstmid_async_drop: got %0d required 0", bus.calc_start); end
      checks++; if (bus.rng_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %0d required 0", bus.rng_ready); end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      stub_lat = 1;
      clear_log();
      send_range(40'd95, 40'd115, 1'b1);
      wait_total(got, tot, ovf, rdy, bsy, tvn);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL rstmid_timeout: got %0d required 1", got); end
      checks++; if (tot !== 64'd99) begin errors++; $display("FAIL rstmid_total: got %0d required 99", tot); end
      checks++; if (n_req !== 1) begin errors++; $display("FAIL rstmid_nreq: got %0d required 1", n_req); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst           = 1'b1;
      bus.rng_valid = 1'b0;
      bus.rng_start = '0;
      bus.rng_end   = '0;
      bus.rng_last  = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_no_match();
      test_empty();
      test_stale_done();
      test_overflow();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/range_dispatcher.md
# range_dispatcher

Front-end initiator for the repeated-half range calculator. It accepts ID ranges over a valid/ready stream and issues one calculator request per half-length K (1..K_MAX) using the calculator's start/done level handshake. It accumulates the returned partial sums into a 64-bit grand total. It publishes the total when the range flagged `last` has finished, and sits between the input range loader and the result reporting logic.

## Interface
- `K_MAX`, default 6: highest half-length K issued. Legal range is 1..12.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `rng_valid` in 1: input range present.
- `rng_ready` out 1: dispatcher can accept a range.
- `rng_start` in 40: inclusive range low bound.
- `rng_end` in 40: inclusive range high bound.
- `rng_last` in 1: final range of the job.
- `calc_start` out 1: level request to the calculator.
- `calc_range_start` out 40: range low bound presented to the calculator.
- `calc_range_end` out 40: range high bound presented to the calculator.
- `calc_k` out 4: K override presented to the calculator. Never 0 while `calc_start` is high.
- `calc_sum` in 64: calculator result. Valid while `calc_done` is high.
- `calc_done` in 1: calculator result ready. Stays high until `calc_start` drops, then clears 2 cycles later.
- `total` out 64: grand total of the job.
- `total_valid` out 1: one-cycle pulse when `total` is updated.
- `overflow` out 1: sticky flag; the accumulator wrapped during the current job.
- `busy` out 1: high in every state except S_IDLE.

## Operation
- State machine: S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_RELEASE, S_RANGE_END.
- S_IDLE:
  - `rng_ready`=1.
  - On `rng_valid`, latch start, end and last into the `calc_range_*` registers and a last flag, set k=1, go to S_CHECK.
  - If `rng_start > rng_end`, the range is treated as empty: go directly to S_RANGE_END.
- S_CHECK, using per-K constants lo_k = 10^(k-1)·(10^k+1) and hi_k = 10^(2k)−1:
  - If end < lo_k: stop. No larger K can match. Go to S_RANGE_END.
  - Else if start > hi_k: skip this K. If k==K_MAX go to S_RANGE_END, else k++ and stay in S_CHECK.
  - Else: `calc_start`<=1, `calc_k`<=k, go to S_ISSUE.
- S_ISSUE: hold `calc_start` high and go to S_WAIT.
- S_WAIT:
  - Hold `calc_start` high.
  - When `calc_done`=1: acc <= acc + `calc_sum` modulo 2^64, set `overflow` if there is a carry out, `calc_start`<=0, go to S_RELEASE.
- S_RELEASE:
  - Hold `calc_start` low until `calc_done`=0 is sampled. This prevents a stale done from being taken as the next result.
  - Then, if k==K_MAX go to S_RANGE_END, else k++ and go to S_CHECK.
- S_RANGE_END:
  - If last: `total`<=acc, `total_valid`<=1 for one cycle, acc<=0. `overflow` stays visible through the `total_valid` cycle and clears on the next accepted range.
  - Go to S_IDLE.
- `calc_range_*` and `calc_k` are stable whenever `calc_start` is high.
- Exactly one request is in flight at a time.
- Reset values:
  - `rng_ready`=0 during reset, 1 from the first cycle after release.
  - `calc_start`=0, `calc_k`=0, `calc_range_*`=0, `total`=0, `total_valid`=0, `overflow`=0, `busy`=0.
  - acc=0, state S_IDLE.
- Reset mid-request: `calc_start` drops asynchronously, and the partial accumulator is discarded. The calculator is reset by the same `rst`.
- `rng_valid` while busy is ignored because `rng_ready`=0. The source holds the range until handshake.

## Timing
- Range accept occurs at the edge where `rng_valid`&`rng_ready`. S_CHECK follows on the next cycle.
- `calc_start` rises at the S_CHECK→S_ISSUE edge, so there is 1 cycle of dispatcher latency from S_CHECK.
- `calc_sum` is sampled on the same edge that `calc_done` is first seen high. `calc_start` falls at that edge.
- S_RELEASE lasts at least 1 cycle, or until `calc_done` low. The next `calc_start` is at least 2 cycles after `calc_done` clears.
- Skip and stop decisions cost 1 cycle per K in S_CHECK.
- `total_valid` is asserted the cycle after S_RANGE_END is entered. `rng_ready` returns the same cycle.
- Per-K constants come from a case on k. The comparisons are registered results of 40-bit compares, one compare per cycle.

## Test plan
- Range 11–22, last=1 → one request with k=1 and `calc_sum`=33; requests for k≥2 are stopped; `total`=33 with a `total_valid` pulse.
- Ranges 11–22, 95–115, 998–1012, 1188511880–1188511890, the last of these flagged last → `total`=33+99+1010+1188511885=1188513027.
- Range 1–10, last=1 → no `calc_start` pulse at all (end 10 < lo_1=11); `total`=0; `total_valid` pulses.
- Range 500–400 (start > end), last=1 → no requests; `total`=0.
- Stub calculator holds `calc_done` high for 5 extra cycles after `calc_start` falls → no double accumulation; the next `calc_start` appears only after `calc_done`=0.
- Stub calculator returns 2^63 twice → `total`=0 and `overflow`=1.
- `rst` pulsed while in S_WAIT → `calc_start`=0 immediately; the next job total excludes the aborted sums.
